// File: rtl/rptr_empty_if.sv
// Read-side bundle between the async-FIFO read pointer block and its user.
// rinc pops one entry on a rising rclk edge only when empty is low; rinc while empty is an underflow.
interface rptr_empty_if #(
    parameter int ADDR_WIDTH = 3
);
    logic                  rinc;
    logic [ADDR_WIDTH:0]   wptr;
    logic [ADDR_WIDTH:0]   rptr;
    logic [ADDR_WIDTH-1:0] raddr;
    logic                  empty;
    logic                  almost_empty;
    logic [ADDR_WIDTH:0]   rcount;
    logic                  underflow;

    modport master (
        output rinc, wptr,
        input  rptr, raddr, empty, almost_empty, rcount, underflow
    );

    modport slave (
        input  rinc, wptr,
        output rptr, raddr, empty, almost_empty, rcount, underflow
    );
endinterface

// File: rtl/rptr_empty.sv
// Read-domain pointer, empty flag and occupancy for the async FIFO.
// The write Gray pointer is brought into rclk through a 2-flop synchronizer.
module rptr_empty #(
    parameter int ADDR_WIDTH = 3,
    parameter int AE_THRESH  = 1
) (
    input  logic          rclk,
    input  logic          r_nrst,
    rptr_empty_if.slave   rif
);
    localparam int PW = ADDR_WIDTH + 1;
    localparam logic [PW-1:0] AE_T = PW'(AE_THRESH);

    logic [PW-1:0] wq1_q, wq2_q;
    logic [PW-1:0] rbin_q, rbin_d;
    logic [PW-1:0] rptr_q, rptr_d;
    logic [PW-1:0] rcount_q, rcount_d;
    logic [PW-1:0] wbin_s;
    logic          empty_q, empty_d;
    logic          ae_q, ae_d;
    logic          uf_q, uf_d;
    logic          pop;

    always_comb begin
        pop      = rif.rinc & ~empty_q;
        rbin_d   = rbin_q + PW'(pop);
        rptr_d   = (rbin_d >> 1) ^ rbin_d;
        // Gray-to-binary: each binary bit is the XOR of all Gray bits at or above it.
        wbin_s   = '0;
        for (int i = 0; i < PW; i++) begin
            wbin_s[i] = ^(wq2_q >> i);
        end
        rcount_d = wbin_s - rbin_d;
        // Comparing the post-pop pointer lets the last pop raise empty on its own edge.
        empty_d  = (rptr_d == wq2_q);
        ae_d     = (rcount_d <= AE_T);
        uf_d     = rif.rinc & empty_q;
    end

    always_ff @(posedge rclk or negedge r_nrst) begin
        if (!r_nrst) begin
            wq1_q    <= '0;
            wq2_q    <= '0;
            rbin_q   <= '0;
            rptr_q   <= '0;
            rcount_q <= '0;
            empty_q  <= 1'b1;
            ae_q     <= 1'b1;
            uf_q     <= 1'b0;
        end else begin
            wq1_q    <= rif.wptr;
            wq2_q    <= wq1_q;
            rbin_q   <= rbin_d;
            rptr_q   <= rptr_d;
            rcount_q <= rcount_d;
            empty_q  <= empty_d;
            ae_q     <= ae_d;
            uf_q     <= uf_d;
        end
    end

    assign rif.rptr         = rptr_q;
    assign rif.raddr        = rbin_q[ADDR_WIDTH-1:0];
    assign rif.empty        = empty_q;
    assign rif.almost_empty = ae_q;
    assign rif.rcount       = rcount_q;
    assign rif.underflow    = uf_q;
endmodule

// File: doc/rptr_empty.md
Name: rptr_empty

Overview:
Read-side pointer and empty-flag generator for the JTAG async FIFO, running entirely in the read clock domain. It is the counterpart of the write-pointer/full block. It brings the write-side Gray pointer into rclk through an internal 2-flop synchronizer. From that it produces the read address, the read Gray pointer (returned to the write side for full detection), a registered empty flag, an occupancy count, almost-empty and underflow indications.

Parameters:
ADDR_WIDTH, 3, FIFO address width; depth = 2^ADDR_WIDTH; pointers are ADDR_WIDTH+1 bits (wrap bit + address).
AE_THRESH, 1, almost_empty asserts when occupancy <= AE_THRESH; legal range 0..2^ADDR_WIDTH.

Ports:
rclk  input  1  read-domain clock.
r_nrst  input  1  asynchronous, active-low reset.
rinc  input  1  read request; pops one entry per cycle when not empty.
wptr  input  ADDR_WIDTH+1  write pointer, Gray coded, from wclk domain (asynchronous to rclk).
rptr  output  ADDR_WIDTH+1  read pointer, Gray coded, registered; sent to write-side synchronizer.
raddr  output  ADDR_WIDTH  memory read address = low ADDR_WIDTH bits of binary read pointer.
empty  output  1  registered FIFO-empty flag.
almost_empty  output  1  registered; occupancy <= AE_THRESH.
rcount  output  ADDR_WIDTH+1  registered occupancy as seen by read side, 0..2^ADDR_WIDTH.
underflow  output  1  one-cycle registered pulse: rinc asserted while empty.

Behaviour:
- One clock, rclk. Reset r_nrst is asynchronous and active-low; all flops clear immediately on assertion, no clock required.
- Reset values:
  - rbin, rptr, raddr, rcount: 0.
  - empty: 1.
  - almost_empty: 1.
  - underflow: 0.
  - Synchronizer stages wq1, wq2: 0.
- Synchronizer: wq1 <= wptr; wq2 <= wq1 on every rclk edge. Only wq2 is used downstream; wptr feeds no other logic.
- Pop qualification: pop = rinc & ~empty, using the registered empty.
- Pointer update:
  - rbin_next = rbin + pop, modulo 2^(ADDR_WIDTH+1).
  - rgray_next = (rbin_next >> 1) ^ rbin_next.
  - rbin <= rbin_next; rptr <= rgray_next.
  - raddr is rbin[ADDR_WIDTH-1:0] (flop output, no combinational path from rinc).
- Empty: empty <= (rgray_next == wq2). It is computed against the post-pop pointer, so the pop of the last entry sets empty on that same edge.
- Occupancy:
  - wbin_s = Gray-to-binary(wq2).
  - rcount <= wbin_s - rbin_next, modulo 2^(ADDR_WIDTH+1).
  - almost_empty <= (that same value <= AE_THRESH).
- Underflow: underflow <= rinc & empty. The pointer does not move on underflow.
- Latency:
  - A wptr change reaches empty/rcount on the 3rd rclk edge after it is stable (2 sync + 1 output register).
  - A pop is reflected on rptr/raddr/empty/rcount at the same edge.
- Wrap-around:
  - rbin wraps 2^(ADDR_WIDTH+1)-1 -> 0.
  - raddr wraps 2^ADDR_WIDTH-1 -> 0.
  - Empty is detected on full-pointer equality, including the wrap bit.
- Simultaneous write update and pop: both are used in the same edge's computation. No event is lost; rcount stays pessimistic (never above true occupancy).
- rptr changes at most one bit per rclk edge (Gray property); verification asserts this.
- Reset mid-operation: all outputs return to reset values asynchronously. On reset release, the block resumes from pointer 0; the write side must be reset concurrently.

Test Plan (ADDR_WIDTH=3, AE_THRESH=1):
1. Assert r_nrst=0 with wptr=5, toggling rclk -> rptr=0, raddr=0, empty=1, almost_empty=1, rcount=0, underflow=0 throughout.
2. After reset, drive wptr=gray(1)=1 -> empty falls and rcount=1 on the 3rd rclk edge, almost_empty stays 1. Then wptr=gray(3)=2 -> three edges later rcount=3, almost_empty=0.
3. With 3 entries, hold rinc for 3 cycles -> raddr steps 0,1,2 then 3; rptr steps 1,3,2; rcount steps 2,1,0; almost_empty=1 after the 2nd pop; empty=1 on the 3rd pop edge; underflow stays 0.
4. rinc=1 while empty for 2 cycles -> rptr/raddr unchanged, underflow=1 on each of those edges, 0 on the following edge.
5. Wrap: feed wptr through gray(16 mod 16), popping continuously -> rbin 15 -> 0, rptr 8 -> 0, raddr 7 -> 0, empty toggles correctly, rptr single-bit changes only.
6. Assert r_nrst mid-stream (rcount=4, raddr=5) between clock edges -> all outputs reset immediately; after release with wptr=0, empty stays 1.
